// File: rtl/nway_plru_cru_pkg.sv
// Shared sizing helpers and tree-vector type for the tree-PLRU replacement unit.
package cru_pkg;

  localparam int unsigned DEF_WAYS = 4;

  // One set's PLRU tree at the default associativity (NUM_WAYS-1 heap-indexed node bits).
  typedef logic [DEF_WAYS-2:0] plru_vec_t;

  function automatic int unsigned offset_size(int unsigned block_size);
    return $clog2(block_size / 8);
  endfunction

  function automatic int unsigned set_size(int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned way_size(int unsigned num_ways);
    return $clog2(num_ways);
  endfunction

  // Depth of heap node n (root is depth 0).
  function automatic int unsigned node_level(int unsigned node);
    return $clog2(node + 2) - 1;
  endfunction

endpackage

// File: rtl/nway_plru_cru_if.sv
// Lookup/update bus between a cache controller and the PLRU replacement unit.
interface nway_plru_cru_if
  import cru_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned NUM_WAYS  = 4
);
  localparam int unsigned WAY_SIZE = way_size(NUM_WAYS);

  logic [ADDR_SIZE-1:0] addr;
  logic [NUM_WAYS-1:0]  valid_ways;
  logic                 access;
  logic [WAY_SIZE-1:0]  hit_way;
  logic                 replace;
  logic [WAY_SIZE-1:0]  victim_way;
  logic                 victim_from_invalid;

  modport master (
    output addr, valid_ways, access, hit_way, replace,
    input  victim_way, victim_from_invalid
  );

  modport slave (
    input  addr, valid_ways, access, hit_way, replace,
    output victim_way, victim_from_invalid
  );
endinterface

// File: rtl/nway_plru_cru_plru_tree.sv
// Victim selection and touch next-state for a single set's tree-PLRU vector.
module plru_tree
  import cru_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = 4,
  localparam int unsigned WAY_SIZE = way_size(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] tree,
  input  logic [NUM_WAYS-1:0] valid_ways,
  input  logic                touch_en,
  input  logic [WAY_SIZE-1:0] touch_way,
  output logic [WAY_SIZE-1:0] victim_c,
  output logic                from_invalid_c,
  output logic [NUM_WAYS-2:0] tree_next_c
);

  logic [NUM_WAYS-1:0] leaf_hit;

  // A leaf is the PLRU victim when every node on its path points toward it.
  for (genvar v = 0; v < NUM_WAYS; v++) begin : g_leaf
    logic [WAY_SIZE-1:0] dir_ok;
    for (genvar l = 0; l < WAY_SIZE; l++) begin : g_lvl
      localparam int unsigned NODE = (1 << l) - 1 + (v >> (WAY_SIZE - l));
      localparam logic        DIR  = 1'((v >> (WAY_SIZE - 1 - l)) & 1);
      assign dir_ok[l] = (tree[NODE] == DIR);
    end
    assign leaf_hit[v] = &dir_ok;
  end

  // Lowest invalid way overrides the tree walk.
  always_comb begin
    victim_c       = '0;
    from_invalid_c = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (leaf_hit[i]) victim_c = WAY_SIZE'(i);
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_ways[i]) begin
        victim_c       = WAY_SIZE'(i);
        from_invalid_c = 1'b1;
      end
    end
  end

  // Nodes on the touched way's path flip to point away from it.
  for (genvar n = 0; n < NUM_WAYS - 1; n++) begin : g_node
    localparam int unsigned LVL = node_level(n);
    localparam int unsigned POS = n + 1 - (1 << LVL);
    logic on_path;
    assign on_path        = touch_en && ((touch_way >> (WAY_SIZE - LVL)) == WAY_SIZE'(POS));
    assign tree_next_c[n] = on_path ? ~touch_way[WAY_SIZE-1-LVL] : tree[n];
  end

endmodule

// File: rtl/nway_plru_cru.sv
// N-way tree-PLRU replacement unit: per-set PLRU flops, combinational victim, touch on hit/refill.
module nway_plru_cru
  import cru_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned NUM_SETS   = 16,
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned NUM_WAYS   = 4
) (
  input  logic            clk,
  input  logic            rst,
  nway_plru_cru_if.slave  bus
);

  localparam int unsigned OFFSET_SIZE = offset_size(BLOCK_SIZE);
  localparam int unsigned SET_SIZE    = set_size(NUM_SETS);
  localparam int unsigned WAY_SIZE    = way_size(NUM_WAYS);

  // Flop array so every set can be cleared in a single reset cycle.
  logic [NUM_WAYS-2:0] plru_q [NUM_SETS];

  logic [SET_SIZE-1:0] set_idx;
  logic [NUM_WAYS-2:0] tree_cur;
  logic [NUM_WAYS-2:0] tree_next;
  logic [WAY_SIZE-1:0] victim;
  logic                from_invalid;
  logic                touch_en;
  logic [WAY_SIZE-1:0] touch_way;
  logic                unused_addr;

  assign set_idx     = bus.addr[OFFSET_SIZE +: SET_SIZE];
  assign tree_cur    = plru_q[set_idx];
  assign unused_addr = ^bus.addr;

  // A refill touches the victim it just consumed and drops any concurrent hit.
  assign touch_en  = bus.access | bus.replace;
  assign touch_way = bus.replace ? victim : bus.hit_way;

  plru_tree #(
    .NUM_WAYS (NUM_WAYS)
  ) u_plru_tree (
    .tree           (tree_cur),
    .valid_ways     (bus.valid_ways),
    .touch_en       (touch_en),
    .touch_way      (touch_way),
    .victim_c       (victim),
    .from_invalid_c (from_invalid),
    .tree_next_c    (tree_next)
  );

  assign bus.victim_way          = victim;
  assign bus.victim_from_invalid = from_invalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else if (touch_en) begin
      plru_q[set_idx] <= tree_next;
    end
  end

endmodule

// File: tb/tb_nway_plru_cru.sv
// Self-checking bench: 4-way/16-set and 2-way/8-set instances against a heap-tree reference model.
module tb_nway_plru_cru;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nway_plru_cru_if #(.ADDR_SIZE(32), .NUM_WAYS(4)) ifa ();
  nway_plru_cru_if #(.ADDR_SIZE(32), .NUM_WAYS(2)) ifb ();

  nway_plru_cru #(.ADDR_SIZE(32), .NUM_SETS(16), .BLOCK_SIZE(32), .NUM_WAYS(4))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  nway_plru_cru #(.ADDR_SIZE(32), .NUM_SETS(8), .BLOCK_SIZE(32), .NUM_WAYS(2))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int errors = 0;
  int checks = 0;

  bit [7:0] ma [16];
  bit [7:0] mb [8];

  // Reference: walk node bits from the root until a leaf is reached.
  function automatic int ref_victim(bit [7:0] t, bit [3:0] valid, int ways, output bit inv);
    int node = 0;
    for (int i = 0; i < ways; i++) begin
      if (!valid[i]) begin
        inv = 1'b1;
        return i;
      end
    end
    inv = 1'b0;
    while (node < ways - 1) node = 2 * node + 1 + int'(t[node]);
    return node - (ways - 1);
  endfunction

  // Reference: descend by way range, pointing each visited node to the other half.
  function automatic bit [7:0] ref_touch(bit [7:0] t, int ways, int w);
    int node = 0;
    int lo   = 0;
    int span = ways;
    while (node < ways - 1) begin
      int half = span / 2;
      if (w < lo + half) begin
        t[node] = 1'b1;
        node    = 2 * node + 1;
      end else begin
        t[node] = 1'b0;
        node    = 2 * node + 2;
        lo      = lo + half;
      end
      span = half;
    end
    return t;
  endfunction

  function automatic logic [31:0] addr_a(int set);
    logic [31:0] r = $urandom;
    r[5:2] = 4'(set);
    return r;
  endfunction

  function automatic logic [31:0] addr_b(int set);
    logic [31:0] r = $urandom;
    r[4:2] = 3'(set);
    return r;
  endfunction

  task automatic idle_inputs();
    ifa.addr = addr_a(0); ifa.valid_ways = 4'hF; ifa.access = 1'b0; ifa.hit_way = 2'd0; ifa.replace = 1'b0;
    ifb.addr = addr_b(0); ifb.valid_ways = 2'b11; ifb.access = 1'b0; ifb.hit_way = 1'b0; ifb.replace = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;
  endtask

  task automatic drive_a(input int set, input bit [3:0] valid, input bit acc, input int hit, input bit rep);
    @(negedge clk);
    ifa.addr = addr_a(set); ifa.valid_ways = valid; ifa.access = acc; ifa.hit_way = 2'(hit); ifa.replace = rep;
    #1;
  endtask

  task automatic drive_b(input int set, input bit [1:0] valid, input bit acc, input int hit, input bit rep);
    @(negedge clk);
    ifb.addr = addr_b(set); ifb.valid_ways = valid; ifb.access = acc; ifb.hit_way = 1'(hit); ifb.replace = rep;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    ifa.addr = addr_a(9); ifa.access = 1'b1; ifa.hit_way = 2'd0; ifa.replace = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int s = 0; s < 4; s++) begin
      drive_a(s * 3, 4'hF, 0, 0, 0);
      checks++;
      if (ifa.victim_way !== 2'd0 || ifa.victim_from_invalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_a set%0d victim=%0d inv=%0d want victim=0 inv=0", s * 3, ifa.victim_way, ifa.victim_from_invalid);
      end
    end
    drive_b(5, 2'b11, 0, 0, 0);
    checks++;
    if (ifb.victim_way !== 1'b0 || ifb.victim_from_invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_b victim=%0d inv=%0d want victim=0 inv=0", ifb.victim_way, ifb.victim_from_invalid);
    end
  endtask

  task automatic test_replace_seq();
    int exp [5] = '{0, 2, 1, 3, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_a(3, 4'hF, 0, 0, k < 4);
      checks++;
      if (ifa.victim_way !== 2'(exp[k]) || ifa.victim_from_invalid !== 1'b0) begin
        errors++;
        $display("FAIL replace_seq step%0d victim=%0d inv=%0d want victim=%0d inv=0", k, ifa.victim_way, ifa.victim_from_invalid, exp[k]);
      end
    end
  endtask

  task automatic test_invalid();
    do_reset();
    drive_a(7, 4'hF, 0, 0, 1);
    drive_a(7, 4'b0000, 0, 0, 0);
    checks++;
    if (ifa.victim_way !== 2'd0 || ifa.victim_from_invalid !== 1'b1) begin
      errors++;
      $display("FAIL invalid_none victim=%0d inv=%0d want victim=0 inv=1", ifa.victim_way, ifa.victim_from_invalid);
    end
    drive_a(7, 4'b0111, 0, 0, 0);
    checks++;
    if (ifa.victim_way !== 2'd3 || ifa.victim_from_invalid !== 1'b1) begin
      errors++;
      $display("FAIL invalid_top victim=%0d inv=%0d want victim=3 inv=1", ifa.victim_way, ifa.victim_from_invalid);
    end
    drive_a(7, 4'b1011, 0, 0, 1);
    checks++;
    if (ifa.victim_way !== 2'd2 || ifa.victim_from_invalid !== 1'b1) begin
      errors++;
      $display("FAIL invalid_1011 victim=%0d inv=%0d want victim=2 inv=1", ifa.victim_way, ifa.victim_from_invalid);
    end
    drive_a(7, 4'hF, 0, 0, 0);
    checks++;
    if (ifa.victim_way !== 2'd1 || ifa.victim_from_invalid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_touch victim=%0d inv=%0d want victim=1 inv=0", ifa.victim_way, ifa.victim_from_invalid);
    end
  endtask

  task automatic test_access();
    do_reset();
    drive_a(5, 4'hF, 1, 0, 0);
    drive_a(5, 4'hF, 1, 2, 0);
    checks++;
    if (ifa.victim_way !== 2'd2) begin
      errors++;
      $display("FAIL access_hit0 victim=%0d want 2", ifa.victim_way);
    end
    drive_a(5, 4'hF, 0, 3, 0);
    checks++;
    if (ifa.victim_way !== 2'd1) begin
      errors++;
      $display("FAIL access_hit2 victim=%0d want 1", ifa.victim_way);
    end
    drive_a(5, 4'hF, 0, 0, 0);
    checks++;
    if (ifa.victim_way !== 2'd1) begin
      errors++;
      $display("FAIL access_ignored victim=%0d want 1", ifa.victim_way);
    end
    drive_a(6, 4'hF, 0, 0, 0);
    checks++;
    if (ifa.victim_way !== 2'd0) begin
      errors++;
      $display("FAIL access_other_set victim=%0d want 0", ifa.victim_way);
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive_a(4, 4'hF, 1, 3, 1);
    checks++;
    if (ifa.victim_way !== 2'd0) begin
      errors++;
      $display("FAIL priority_pre victim=%0d want 0", ifa.victim_way);
    end
    drive_a(4, 4'hF, 0, 0, 0);
    checks++;
    if (ifa.victim_way !== 2'd2) begin
      errors++;
      $display("FAIL priority_post victim=%0d want 2", ifa.victim_way);
    end
  endtask

  task automatic test_reset_sweep();
    do_reset();
    drive_a(1, 4'hF, 0, 0, 1);
    drive_a(6, 4'hF, 0, 0, 1);
    drive_a(11, 4'hF, 1, 3, 0);
    drive_a(15, 4'hF, 0, 0, 1);
    drive_b(3, 2'b11, 0, 0, 1);
    drive_a(6, 4'hF, 0, 0, 0);
    checks++;
    if (ifa.victim_way !== 2'd2) begin
      errors++;
      $display("FAIL sweep_pre victim=%0d want 2", ifa.victim_way);
    end
    @(negedge clk);
    rst = 1'b1;
    ifa.addr = addr_a(0); ifa.access = 1'b1; ifa.hit_way = 2'd1; ifa.replace = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int s = 0; s < 16; s++) begin
      drive_a(s, 4'hF, 0, 0, 0);
      checks++;
      if (ifa.victim_way !== 2'd0 || ifa.victim_from_invalid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_a set%0d victim=%0d inv=%0d want victim=0 inv=0", s, ifa.victim_way, ifa.victim_from_invalid);
      end
    end
    drive_b(3, 2'b11, 0, 0, 0);
    checks++;
    if (ifb.victim_way !== 1'b0) begin
      errors++;
      $display("FAIL sweep_b victim=%0d want 0", ifb.victim_way);
    end
  endtask

  task automatic test_two_way();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_b(2, 2'b11, 0, 0, 1);
      checks++;
      if (ifb.victim_way !== 1'(k % 2) || ifb.victim_from_invalid !== 1'b0) begin
        errors++;
        $display("FAIL two_way step%0d victim=%0d inv=%0d want victim=%0d inv=0", k, ifb.victim_way, ifb.victim_from_invalid, k % 2);
      end
    end
    drive_b(2, 2'b11, 1, 0, 0);
    drive_b(2, 2'b11, 0, 0, 0);
    checks++;
    if (ifb.victim_way !== 1'b1) begin
      errors++;
      $display("FAIL two_way_hit0 victim=%0d want 1", ifb.victim_way);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      int       sa, sb, ha, hb, ea, eb;
      bit [3:0] va;
      bit [1:0] vb;
      bit       aa, ra, ab, rb, ia, ib, r;
      sa = int'($urandom_range(15)); sb = int'($urandom_range(7));
      va = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      vb = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
      aa = 1'($urandom); ra = ($urandom_range(2) == 0);
      ab = 1'($urandom); rb = ($urandom_range(2) == 0);
      ha = int'($urandom_range(3)); hb = int'($urandom_range(1));
      r  = ($urandom_range(99) == 0);
      @(negedge clk);
      rst = r;
      ifa.addr = addr_a(sa); ifa.valid_ways = va; ifa.access = aa; ifa.hit_way = 2'(ha); ifa.replace = ra;
      ifb.addr = addr_b(sb); ifb.valid_ways = vb; ifb.access = ab; ifb.hit_way = 1'(hb); ifb.replace = rb;
      #1;
      ea = ref_victim(ma[sa], va, 4, ia);
      eb = ref_victim(mb[sb], {2'b11, vb}, 2, ib);
      checks++;
      if (ifa.victim_way !== 2'(ea) || ifa.victim_from_invalid !== ia) begin
        errors++;
        $display("FAIL random_a cyc%0d set%0d victim=%0d inv=%0d want victim=%0d inv=%0d", c, sa, ifa.victim_way, ifa.victim_from_invalid, ea, ia);
      end
      checks++;
      if (ifb.victim_way !== 1'(eb) || ifb.victim_from_invalid !== ib) begin
        errors++;
        $display("FAIL random_b cyc%0d set%0d victim=%0d inv=%0d want victim=%0d inv=%0d", c, sb, ifb.victim_way, ifb.victim_from_invalid, eb, ib);
      end
      if (r) begin
        foreach (ma[i]) ma[i] = '0;
        foreach (mb[i]) mb[i] = '0;
      end else begin
        if (ra)      ma[sa] = ref_touch(ma[sa], 4, ea);
        else if (aa) ma[sa] = ref_touch(ma[sa], 4, ha);
        if (rb)      mb[sb] = ref_touch(mb[sb], 2, eb);
        else if (ab) mb[sb] = ref_touch(mb[sb], 2, hb);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_replace_seq();
    test_invalid();
    test_access();
    test_priority();
    test_reset_sweep();
    test_two_way();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nway_plru_cru.md
NWAY_PLRU_CRU -- requirements
Module: nway_plru_cru

Interface
REQ-001 Parameter ADDR_SIZE, default 32, address width in bits.
REQ-002 Parameter NUM_SETS, default 16, number of sets; power of 2, >=2.
REQ-003 Parameter BLOCK_SIZE, default 32, block size in bits; BLOCK_SIZE/8 a power of 2.
REQ-004 Parameter NUM_WAYS, default 4, associativity; power of 2, >=2.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 addr  input  ADDR_SIZE  access address; set index = addr[OFFSET_SIZE +: SET_SIZE], OFFSET_SIZE = clog2(BLOCK_SIZE/8), SET_SIZE = clog2(NUM_SETS).
REQ-008 valid_ways  input  NUM_WAYS  valid bits of the addressed set, bit i = way i.
REQ-009 access  input  1  hit pulse; marks hit_way as most recently used.
REQ-010 hit_way  input  WAY_SIZE  hitting way index, WAY_SIZE = clog2(NUM_WAYS).
REQ-011 replace  input  1  refill pulse; marks victim_way as most recently used.
REQ-012 victim_way  output  WAY_SIZE  way to replace in the addressed set.
REQ-013 victim_from_invalid  output  1  high when victim_way was chosen because of an invalid way.

Function
REQ-014 State: one tree-PLRU vector of NUM_WAYS-1 bits per set, nodes heap-indexed (root 0, children of node n are 2n+1 and 2n+2).
- Node bit 0 = LRU side is left (lower ways); 1 = LRU side is right.
REQ-015 victim_way and victim_from_invalid are combinational from addr, valid_ways and current state; zero-cycle latency.
REQ-016 If any valid_ways bit is 0, victim_way = lowest-index invalid way and victim_from_invalid = 1.
REQ-017 Otherwise victim_way = leaf reached by walking from root following each node bit, and victim_from_invalid = 0.
REQ-018 Touching way w: each node on the root-to-w path is set to point away from w (0 if w is in the right subtree, 1 if in the left); off-path nodes unchanged.
REQ-019 access=1, replace=0: touch hit_way in the addressed set at the next rising edge.
REQ-020 replace=1: touch victim_way as computed that cycle; replace has priority over a simultaneous access, whose update is dropped.
REQ-021 Only the addressed set updates; all other sets hold.
REQ-022 access=0 and replace=0: no state change.
REQ-023 hit_way is ignored when access=0; addr bits above the set index are ignored.
REQ-024 An update becomes visible on victim_way in the cycle after the edge that applies it.
REQ-025 Back-to-back updates to the same set each cycle apply in order, with no lost updates.
REQ-026 NUM_WAYS=2: a single bit per set; touching way 0 sets it to 1, touching way 1 sets it to 0.

Reset
REQ-027 rst=1 at a rising edge clears the PLRU bits of all NUM_SETS sets to 0, regardless of addr.
REQ-028 rst has priority over access and replace in the same cycle.
REQ-029 After reset, a fully valid set gives victim_way = 0 and victim_from_invalid = 0.
REQ-030 Asserting rst mid-sequence discards all history; the next victim for a full set is way 0.

Structure
REQ-031 Package cru_pkg holds the address-split localparam functions (OFFSET_SIZE, SET_SIZE, WAY_SIZE) and the PLRU tree-vector typedef.
REQ-032 Sub-module plru_tree (one set's next-state and victim logic, parametrised by NUM_WAYS) is instantiated once on the addressed set's vector.
REQ-033 The state array is flops, not RAM, so that single-cycle full reset is possible.

Verification
REQ-034 Reset, NUM_WAYS=4, valid_ways=4'b1111, then 4 consecutive replace pulses to set 3 -> victim_way before each edge = 0, 2, 1, 3; after the 4th edge victim_way = 0.
REQ-035 valid_ways=4'b1011 with any tree state -> victim_way=2 and victim_from_invalid=1; a replace touches way 2.
REQ-036 After reset, full set: access with hit_way=0 -> victim 2; access with hit_way=2 -> victim 1 (set 5), while set 6 still gives victim 0.
REQ-037 Same cycle: access=1, hit_way=3, replace=1, victim 0 -> only way 0 is touched; next victim_way = 2.
REQ-038 Touch several sets, then assert rst for one cycle with addr pointing at set 0 -> every set (sweep all 16) gives victim 0.
REQ-039 NUM_WAYS=2, NUM_SETS=8: alternating replace pulses toggle victim_way 0, 1, 0, 1; random access/replace streams are checked against a per-set reference model.
